decode_stage: RTL and testbench
===============================

# decode_stage

Registered, parametrised instruction-decode stage sitting between the fetch buffer and the ALU/register-file read stage.
- Splits each instruction word into opcode, two source registers, a destination register and an immediate.
- Carries configurable field widths and optional immediate sign-extension.
- Registers its outputs behind a valid/ready handshake.
- Keeps a per-register busy scoreboard, so an instruction whose sources are still being produced is held at the input until the matching writeback.

## Interface

Parameters:
- XLEN, 32, instruction and immediate width
- OP_W, 3, opcode field width
- REG_AW, 5, register-index width; 2**REG_AW architectural registers
- IMM_W, 5, immediate field width
- SIGN_EXT, 0, 1 = sign-extend immediate, 0 = zero-extend
- IMM_OP_MIN, 6, opcodes >= this value are immediate-form

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instr is valid
- in_ready  out  1  stage accepts instr this cycle
- instr  in  XLEN  instruction word
- flush  in  1  kill held instruction and clear scoreboard
- wb_valid  in  1  writeback completes this cycle
- wb_rd  in  REG_AW  register written back
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream accepts
- ALUop  out  OP_W  opcode
- rs1, rs2, rd  out  REG_AW each  register indices
- imm  out  XLEN  extended immediate
- isImmediate  out  1  ALUop >= IMM_OP_MIN

## Operation

- Field layout is packed from the MSB:
  - op = instr[XLEN-1 -: OP_W], followed by rs1, rs2 and rd, each REG_AW bits.
  - imm = instr[IMM_W-1:0].
  - Bits between rd and imm are ignored.
  - Legal configurations require OP_W + 3*REG_AW + IMM_W <= XLEN; synthesis fails otherwise.
- Immediate extension:
  - SIGN_EXT=0: upper XLEN-IMM_W bits of imm are 0.
  - SIGN_EXT=1: upper bits replicate instr[IMM_W-1].
- Scoreboard:
  - busy[2**REG_AW-1:0], one bit per register.
  - Register 0 is never marked busy.
- Hazard, evaluated on the incoming instr:
  - hazard = src_busy(rs1) | (!imm_form & src_busy(rs2)).
  - src_busy(r) = busy[r] & !(wb_valid & wb_rd==r). Writeback bypasses the hazard in the same cycle.
- in_ready = !flush & !hazard & (!out_valid | out_ready).
- Accept (in_valid & in_ready):
  - Output registers load the decoded fields.
  - out_valid is set to 1.
  - busy[rd] is set if rd != 0.
- Output drain: if out_ready and no accept, out_valid clears. The output fields hold their last values.
- Output stability: while out_valid & !out_ready, all output fields are stable.
- Writeback: wb_valid clears busy[wb_rd].
- Writeback and accept in the same cycle on the same register: the set wins, because the new producer owns it.
- Flush:
  - out_valid is cleared and busy is cleared entirely.
  - No accept occurs that cycle, and wb is ignored.
  - in_ready is 0 during flush.

## Timing

- Reset (rst_n low, asynchronous):
  - out_valid = 0, all busy = 0.
  - ALUop, rs1, rs2, rd, imm and isImmediate = 0.
  - in_ready becomes 1 once reset is released and flush is low.
- Latency: decoded fields appear one cycle after the accepting edge.
- Throughput: one instruction per cycle when out_ready is high and there is no hazard.
- in_ready is combinational from out_valid, out_ready, instr, busy, wb_valid, wb_rd and flush. There is no combinational path from in_valid to in_ready.
- A back-to-back dependent instruction stalls at least until the producer's wb_valid cycle. It is accepted in that same cycle via the bypass.
- Reset asserted mid-stall drops the held instruction. Upstream must re-present it.

## Test plan

- Reset then decode: instr=0x2110_C000 with in_valid=1, out_ready=1.
  - Required next cycle: out_valid=1, ALUop=1, rs1=1, rs2=2, rd=3, imm=0, isImmediate=0.
  - Required scoreboard state: busy[3]=1.
- RAW stall: after the instruction above, present 0x0301_0000 (rs1=3, rd=4).
  - Required: in_ready=0 until wb_valid=1, wb_rd=3.
  - In that cycle: in_ready=1, the instruction is accepted, busy[3]=0 and busy[4]=1.
- Immediate form: busy[5]=1, instr=0xC029_C01F.
  - Required: accepted with no stall, because rs2 is ignored.
  - Required outputs: isImmediate=1, rd=7, imm=0x0000_001F. With SIGN_EXT=1, imm=0xFFFF_FFFF.
- Backpressure: out_ready=0 for 3 cycles with in_valid held.
  - Required: in_ready=0 and all outputs stable.
  - When out_ready returns to 1: the next instruction loads on that edge.
- Same-register writeback and accept: busy[3]=1 while writeback wb_rd=3 coincides with accepting an instruction whose rd=3.
  - Required: busy[3]=1 afterwards.
  - Writeback of r0 has no effect, and r0 is never marked busy.
- Flush and reset mid-operation:
  - flush=1 with out_valid=1 and busy[3]=busy[4]=1: required next cycle out_valid=0 and busy all 0.
  - Asynchronous rst_n drop mid-cycle: required immediate out_valid=0.

Source files
------------

// File: rtl/decode_stage_if.sv
// Handshake and writeback bundle between the fetch buffer, decode_stage and the ALU/regfile read stage.
// master = upstream/downstream environment, slave = the decode stage itself.
interface decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int OP_W   = 3,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   instr;
  logic              flush;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   ALUop;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm;
  logic              isImmediate;

  modport master (
    output in_valid, instr, flush, wb_valid, wb_rd, out_ready,
    input  in_ready, out_valid, ALUop, rs1, rs2, rd, imm, isImmediate
  );

  modport slave (
    input  in_valid, instr, flush, wb_valid, wb_rd, out_ready,
    output in_ready, out_valid, ALUop, rs1, rs2, rd, imm, isImmediate
  );
endinterface

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with a per-register busy scoreboard that
// holds RAW-dependent instructions at the input until the producer writes back.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int OP_W       = 3,
  parameter int REG_AW     = 5,
  parameter int IMM_W      = 5,
  parameter int SIGN_EXT   = 0,
  parameter int IMM_OP_MIN = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);
  localparam int NREG   = 2 ** REG_AW;
  localparam int RS1_HI = XLEN - OP_W - 1;
  localparam int RS2_HI = RS1_HI - REG_AW;
  localparam int RD_HI  = RS2_HI - REG_AW;
  localparam logic [31:0] IMM_MIN_U = IMM_OP_MIN;

  generate
    if (OP_W + 3 * REG_AW + IMM_W > XLEN) begin : g_bad_layout
      $error("decode_stage: OP_W + 3*REG_AW + IMM_W exceeds XLEN");
    end
  endgenerate

  logic [NREG-1:0]   busy_q, busy_d;
  logic              out_valid_q, out_valid_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              is_imm_q, is_imm_d;

  logic [OP_W-1:0]   dec_op;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_imm_form;
  logic              ext_bit;
  logic              rs1_busy, rs2_busy, hazard, in_ready, accept;

  always_comb begin
    dec_op       = bus.instr[XLEN-1 -: OP_W];
    dec_rs1      = bus.instr[RS1_HI -: REG_AW];
    dec_rs2      = bus.instr[RS2_HI -: REG_AW];
    dec_rd       = bus.instr[RD_HI -: REG_AW];
    ext_bit      = (SIGN_EXT != 0) ? bus.instr[IMM_W-1] : 1'b0;
    dec_imm      = {{(XLEN-IMM_W){ext_bit}}, bus.instr[IMM_W-1:0]};
    dec_imm_form = (32'(dec_op) >= IMM_MIN_U);

    // A writeback landing this cycle releases its register for the incoming instruction.
    rs1_busy = busy_q[dec_rs1] & ~(bus.wb_valid & (bus.wb_rd == dec_rs1));
    rs2_busy = busy_q[dec_rs2] & ~(bus.wb_valid & (bus.wb_rd == dec_rs2));
    hazard   = rs1_busy | (~dec_imm_form & rs2_busy);
    in_ready = ~bus.flush & ~hazard & (~out_valid_q | bus.out_ready);
    accept   = bus.in_valid & in_ready;
  end

  always_comb begin
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    imm_d       = imm_q;
    is_imm_d    = is_imm_q;

    if (bus.flush) begin
      busy_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      if (bus.wb_valid) begin
        busy_d[bus.wb_rd] = 1'b0;
      end
      // Set after clear: a new producer of the same register owns it.
      if (accept && (dec_rd != '0)) begin
        busy_d[dec_rd] = 1'b1;
      end
      if (accept) begin
        out_valid_d = 1'b1;
        alu_op_d    = dec_op;
        rs1_d       = dec_rs1;
        rs2_d       = dec_rs2;
        rd_d        = dec_rd;
        imm_d       = dec_imm;
        is_imm_d    = dec_imm_form;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      alu_op_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      is_imm_q    <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      is_imm_q    <= is_imm_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.ALUop       = alu_op_q;
  assign bus.rs1         = rs1_q;
  assign bus.rs2         = rs2_q;
  assign bus.rd          = rd_q;
  assign bus.imm         = imm_q;
  assign bus.isImmediate = is_imm_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: a zero-extending and a sign-extending instance share stimulus;
// an abstract scoreboard/decoder model is compared every cycle, plus literal checks.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        out_ready = 1'b0;
  logic        cmp_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .OP_W(3), .REG_AW(5)) bus0 ();
  decode_stage_if #(.XLEN(32), .OP_W(3), .REG_AW(5)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.instr     = instr;
  assign bus0.flush     = flush;
  assign bus0.wb_valid  = wb_valid;
  assign bus0.wb_rd     = wb_rd;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.instr     = instr;
  assign bus1.flush     = flush;
  assign bus1.wb_valid  = wb_valid;
  assign bus1.wb_rd     = wb_rd;
  assign bus1.out_ready = out_ready;

  decode_stage #(.XLEN(32), .OP_W(3), .REG_AW(5), .IMM_W(5), .SIGN_EXT(0), .IMM_OP_MIN(6))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  decode_stage #(.XLEN(32), .OP_W(3), .REG_AW(5), .IMM_W(5), .SIGN_EXT(1), .IMM_OP_MIN(6))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Abstract model: fields by shift/mask arithmetic, busy as a plain bit table.
  logic [31:0] m_busy;
  logic        m_valid;
  int unsigned m_op, m_rs1, m_rs2, m_rd;
  logic [31:0] m_imm0, m_imm1;
  logic        m_isimm;

  function automatic int unsigned f_op(input logic [31:0] w);  return w >> 29;         endfunction
  function automatic int unsigned f_rs1(input logic [31:0] w); return (w >> 24) & 31;  endfunction
  function automatic int unsigned f_rs2(input logic [31:0] w); return (w >> 19) & 31;  endfunction
  function automatic int unsigned f_rd(input logic [31:0] w);  return (w >> 14) & 31;  endfunction
  function automatic logic [31:0] f_zimm(input logic [31:0] w); return w & 32'd31;     endfunction
  function automatic logic [31:0] f_simm(input logic [31:0] w);
    return ((w & 32'd16) != 0) ? (w | 32'hFFFF_FFE0) : (w & 32'd31);
  endfunction

  function automatic logic src_busy(input int unsigned r);
    return m_busy[r] && !(wb_valid && (int'(wb_rd) == r));
  endfunction

  function automatic logic exp_ready();
    logic hz;
    hz = src_busy(f_rs1(instr)) || ((f_op(instr) < 6) && src_busy(f_rs2(instr)));
    return !flush && !hz && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] busy_after();
    logic [31:0] b;
    b = m_busy;
    if (wb_valid) b[wb_rd] = 1'b0;
    if (in_valid && exp_ready() && f_rd(instr) != 0) b[f_rd(instr)] = 1'b1;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0; m_valid <= 1'b0; m_op <= 0; m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0;
      m_imm0 <= '0; m_imm1 <= '0; m_isimm <= 1'b0;
    end else if (flush) begin
      m_busy  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_busy <= busy_after();
      if (in_valid && exp_ready()) begin
        m_valid <= 1'b1;
        m_op <= f_op(instr); m_rs1 <= f_rs1(instr); m_rs2 <= f_rs2(instr); m_rd <= f_rd(instr);
        m_imm0 <= f_zimm(instr); m_imm1 <= f_simm(instr); m_isimm <= (f_op(instr) >= 6);
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("in_ready0", 64'(bus0.in_ready), 64'(exp_ready()));
      chk("in_ready1", 64'(bus1.in_ready), 64'(exp_ready()));
      chk("fields0", 64'({bus0.out_valid, bus0.ALUop, bus0.rs1, bus0.rs2, bus0.rd, bus0.isImmediate}),
          64'({m_valid, 3'(m_op), 5'(m_rs1), 5'(m_rs2), 5'(m_rd), m_isimm}));
      chk("fields1", 64'({bus1.out_valid, bus1.ALUop, bus1.rs1, bus1.rs2, bus1.rd, bus1.isImmediate}),
          64'({m_valid, 3'(m_op), 5'(m_rs1), 5'(m_rs2), 5'(m_rd), m_isimm}));
      chk("imm_zext", 64'(bus0.imm), 64'(m_imm0));
      chk("imm_sext", 64'(bus1.imm), 64'(m_imm1));
      chk("busy", 64'(dut0.busy_q), 64'(m_busy));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [2:0] r_op;
  logic [1:0] r_a, r_b, r_c;
  logic [4:0] r_imm;

  initial begin
    // Reset state
    repeat (2) at_neg();
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_fields", 64'({bus0.ALUop, bus0.rs1, bus0.rs2, bus0.rd, bus0.isImmediate}), 64'd0);
    chk("rst_imm", 64'(bus1.imm), 64'd0);
    chk("rst_busy", 64'(dut0.busy_q), 64'd0);
    #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    cmp_en = 1'b1;

    // Basic decode
    tick();
    in_valid = 1'b1; instr = 32'h2110_C000; out_ready = 1'b1;
    tick();
    in_valid = 1'b1; instr = 32'h0301_0000;
    at_neg();
    chk("dec_fields", 64'({bus0.out_valid, bus0.ALUop, bus0.rs1, bus0.rs2, bus0.rd, bus0.isImmediate}),
        64'({1'b1, 3'd1, 5'd1, 5'd2, 5'd3, 1'b0}));
    chk("dec_imm", 64'(bus0.imm), 64'd0);
    chk("dec_busy3", 64'(dut0.busy_q[3]), 64'd1);

    // RAW stall until writeback of r3, accepted in the writeback cycle
    chk("raw_stall0", 64'(bus0.in_ready), 64'd0);
    tick();
    at_neg();
    chk("raw_stall1", 64'(bus0.in_ready), 64'd0);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3;
    at_neg();
    chk("raw_bypass", 64'(bus0.in_ready), 64'd1);
    tick();
    wb_valid = 1'b0; instr = 32'h0001_4000;
    at_neg();
    chk("raw_busy34", 64'({dut0.busy_q[4], dut0.busy_q[3]}), 64'b10);
    chk("raw_rd", 64'(bus0.rd), 64'd4);

    // Immediate form ignores busy rs2 (r5)
    tick();
    instr = 32'hC029_C01F;
    at_neg();
    chk("imm_busy5", 64'(dut0.busy_q[5]), 64'd1);
    chk("imm_ready", 64'(bus0.in_ready), 64'd1);
    tick();
    out_ready = 1'b0; instr = 32'h4002_0000;
    at_neg();
    chk("imm_fields", 64'({bus0.isImmediate, bus0.rd}), 64'({1'b1, 5'd7}));
    chk("imm_zext_lit", 64'(bus0.imm), 64'h1F);
    chk("imm_sext_lit", 64'(bus1.imm), 64'hFFFF_FFFF);

    // Backpressure for three cycles
    for (int i = 0; i < 3; i++) begin
      if (i != 0) at_neg();
      chk("bp_ready", 64'(bus0.in_ready), 64'd0);
      chk("bp_hold", 64'({bus0.out_valid, bus0.rd}), 64'({1'b1, 5'd7}));
      tick();
    end
    out_ready = 1'b1;
    at_neg();
    chk("bp_release", 64'(bus0.in_ready), 64'd1);
    tick();
    instr = 32'h0000_C000;
    at_neg();
    chk("bp_next", 64'(bus0.rd), 64'd8);

    // Same-register writeback and accept: set wins; r0 never busy
    tick();
    wb_valid = 1'b1; wb_rd = 5'd3;
    tick();
    wb_valid = 1'b0;
    at_neg();
    chk("same_reg_busy3", 64'(dut0.busy_q[3]), 64'd1);
    tick();
    wb_valid = 1'b1; wb_rd = 5'd0; instr = 32'h0000_0000;
    tick();
    wb_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    at_neg();
    chk("r0_busy", 64'(dut0.busy_q[0]), 64'd0);

    // Flush with output valid and r3/r4 busy
    chk("pre_flush", 64'({bus0.out_valid, dut0.busy_q[4], dut0.busy_q[3]}), 64'b111);
    tick();
    flush = 1'b1; in_valid = 1'b1; instr = 32'h0000_4000;
    at_neg();
    chk("flush_ready", 64'(bus0.in_ready), 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    at_neg();
    chk("flush_state", 64'({bus0.out_valid, dut0.busy_q}), 64'd0);

    // Asynchronous reset mid-stall
    tick();
    in_valid = 1'b1; instr = 32'h0000_C000;
    tick();
    instr = 32'h0300_0000;
    at_neg();
    chk("arst_stall", 64'(bus0.in_ready), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("arst_out_valid", 64'({bus0.out_valid, bus1.out_valid}), 64'd0);
    chk("arst_busy", 64'(dut0.busy_q), 64'd0);
    at_neg();
    #1 rst_n = 1'b1;
    #1 chk("arst_ready", 64'(bus0.in_ready), 64'd1);
    in_valid = 1'b0;

    // Mixed traffic on a few registers; model checks every cycle
    for (int i = 0; i < 80; i++) begin
      tick();
      r_op = 3'($urandom_range(7)); r_a = 2'($urandom_range(3));
      r_b = 2'($urandom_range(3));  r_c = 2'($urandom_range(3));
      r_imm = 5'($urandom_range(31));
      instr     = {r_op, 3'b0, r_a, 3'b0, r_b, 3'b0, r_c, 9'b0, r_imm};
      in_valid  = 1'($urandom_range(1));
      wb_valid  = 1'($urandom_range(1));
      wb_rd     = {3'b0, 2'($urandom_range(3))};
      out_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(19) == 0);
    end
    tick();
    in_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    repeat (2) at_neg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
